// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/response bus
interface if_fetch_stage_if #(
  parameter int WIDTH  = 8,
  parameter int DATA_W = 32
) ();

  logic              imem_req;
  logic [WIDTH-1:0]  imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous DEPTH-entry FIFO with clear, count and head outputs
module if_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear_i && push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - one-outstanding-request fetch stage with instruction buffer
// and flush handling; drop marks an in-flight response that must be discarded.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pc_in,
  output logic                     pc_en,
  input  logic                     flush,
  if_fetch_stage_if.master         imem,
  output logic                     instr_valid,
  output logic [DATA_W-1:0]        instr,
  output logic [WIDTH-1:0]         instr_pc,
  input  logic                     id_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0]  pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  state_t           state_q, state_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             push, pop;
  entry_t           push_entry, head;
  logic [CW-1:0]    count;

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    req_pc_d      = req_pc_q;
    push          = 1'b0;
    imem.imem_req = 1'b0;
    pc_en         = 1'b0;
    case (state_q)
      ISSUE: begin
        // Gating with rst keeps the bus quiet while reset is held.
        imem.imem_req = !rst && !flush && (count < FULL);
        if (imem.imem_req && imem.imem_gnt) begin
          pc_en    = 1'b1;
          req_pc_d = pc_in;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          if (imem.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem.imem_rvalid) begin
          push    = !drop_q;
          drop_d  = 1'b0;
          state_d = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ISSUE;
      drop_q   <= 1'b0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign push_entry = '{pc: req_pc_q, instr: imem.imem_rdata};
  assign pop        = instr_valid && id_ready && !flush;

  if_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign imem.imem_addr = imem.imem_req ? pc_in : '0;
  assign instr_valid    = (count != '0);
  assign instr          = instr_valid ? head.instr : DATA_W'(NOP);
  assign instr_pc       = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - per-cycle vector bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        gnt;
    logic        rvalid;
    logic        rdy;
    logic [7:0]  pc;
    logic [31:0] rdata;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_pen;
    logic        e_val;
    logic [31:0] e_ins;
    logic [7:0]  e_ipc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc_in = '0;
  logic        pc_en;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        id_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  if_fetch_stage_if #(.WIDTH(8), .DATA_W(32)) imem_bus ();

  if_fetch_stage #(.WIDTH(8), .DATA_W(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_en       (pc_en),
    .flush       (flush),
    .imem        (imem_bus.master),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .id_ready    (id_ready)
  );

  always #5 clk = ~clk;

  initial begin
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
  end

  function automatic vec_t mk(input logic r, input logic f, input logic g, input logic rv,
                              input logic rd, input logic [7:0] pc, input logic [31:0] dat,
                              input logic req, input logic [7:0] addr, input logic pen,
                              input logic val, input logic [31:0] ins, input logic [7:0] ipc);
    vec_t v;
    v = '{rst: r, flush: f, gnt: g, rvalid: rv, rdy: rd, pc: pc, rdata: dat,
          e_req: req, e_addr: addr, e_pen: pen, e_val: val, e_ins: ins, e_ipc: ipc};
    return v;
  endfunction

  task automatic chk(input int idx, input string nm, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %h want %h", idx, nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst                  = v.rst;
    flush                = v.flush;
    imem_bus.imem_gnt    = v.gnt;
    imem_bus.imem_rvalid = v.rvalid;
    imem_bus.imem_rdata  = v.rdata;
    id_ready             = v.rdy;
    pc_in                = v.pc;
    #1;
    chk(n_vec, "imem_req", {31'd0, imem_bus.imem_req}, {31'd0, v.e_req});
    chk(n_vec, "imem_addr", {24'd0, imem_bus.imem_addr}, {24'd0, v.e_addr});
    chk(n_vec, "pc_en", {31'd0, pc_en}, {31'd0, v.e_pen});
    chk(n_vec, "instr_valid", {31'd0, instr_valid}, {31'd0, v.e_val});
    chk(n_vec, "instr", instr, v.e_ins);
    chk(n_vec, "instr_pc", {24'd0, instr_pc}, {24'd0, v.e_ipc});
    n_vec++;
  endtask

  initial begin
    // rst flush gnt rvalid rdy pc rdata | req addr pen val instr ipc
    // basic fetch, response two cycles after grant, popped immediately
    tbl.push_back(mk(1,0,0,0,0, 8'h00, 32'h0,        0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(1,0,0,0,0, 8'h10, 32'h0,        0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,0,1, 8'h10, 32'h0,        1,8'h10,1, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,0,1, 8'h14, 32'h0,        0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,1,1, 8'h14, 32'h00500093, 0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,0,0,1, 8'h14, 32'h0,        1,8'h14,0, 1,32'h00500093,8'h10));
    tbl.push_back(mk(0,0,0,0,1, 8'h14, 32'h0,        1,8'h14,0, 0,NOP,8'h00));
    // decode stalled: buffer fills to DEPTH, then drains in order
    tbl.push_back(mk(1,0,0,0,0, 8'h10, 32'h0,        0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,0,0, 8'h10, 32'h0,        1,8'h10,1, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,1,0, 8'h14, 32'h00A00001, 0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,0,0, 8'h14, 32'h0,        1,8'h14,1, 1,32'h00A00001,8'h10));
    tbl.push_back(mk(0,0,1,1,0, 8'h18, 32'h00A00002, 0,8'h00,0, 1,32'h00A00001,8'h10));
    tbl.push_back(mk(0,0,1,0,0, 8'h18, 32'h0,        0,8'h00,0, 1,32'h00A00001,8'h10));
    tbl.push_back(mk(0,0,1,0,0, 8'h18, 32'h0,        0,8'h00,0, 1,32'h00A00001,8'h10));
    tbl.push_back(mk(0,0,0,0,1, 8'h18, 32'h0,        0,8'h00,0, 1,32'h00A00001,8'h10));
    tbl.push_back(mk(0,0,0,0,1, 8'h18, 32'h0,        1,8'h18,0, 1,32'h00A00002,8'h14));
    tbl.push_back(mk(0,0,0,0,1, 8'h18, 32'h0,        1,8'h18,0, 0,NOP,8'h00));
    // flush in WAIT before rvalid: buffer cleared, late response dropped
    tbl.push_back(mk(0,0,1,0,0, 8'h18, 32'h0,        1,8'h18,1, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,0,1,0, 8'h1C, 32'h00A00003, 0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,0,0, 8'h1C, 32'h0,        1,8'h1C,1, 1,32'h00A00003,8'h18));
    tbl.push_back(mk(0,1,0,0,0, 8'h1C, 32'h0,        0,8'h00,0, 1,32'h00A00003,8'h18));
    tbl.push_back(mk(0,0,1,0,0, 8'h40, 32'h0,        0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,1,0, 8'h40, 32'hDEADBEEF, 0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,0,0, 8'h40, 32'h0,        1,8'h40,1, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,0,1,0, 8'h44, 32'h00A00004, 0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,0,0,1, 8'h44, 32'h0,        1,8'h44,0, 1,32'h00A00004,8'h40));
    tbl.push_back(mk(0,0,0,0,0, 8'h44, 32'h0,        1,8'h44,0, 0,NOP,8'h00));
    // flush coinciding with rvalid, then flush while idle in ISSUE
    tbl.push_back(mk(0,0,1,0,0, 8'h44, 32'h0,        1,8'h44,1, 0,NOP,8'h00));
    tbl.push_back(mk(0,1,1,1,0, 8'h48, 32'h00A00005, 0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,1,0,0, 8'h48, 32'h0,        1,8'h48,1, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,0,1,0, 8'h4C, 32'h00A00006, 0,8'h00,0, 0,NOP,8'h00));
    tbl.push_back(mk(0,0,0,0,1, 8'h4C, 32'h0,        1,8'h4C,0, 1,32'h00A00006,8'h48));
    tbl.push_back(mk(0,1,1,0,0, 8'h4C, 32'h0,        0,8'h00,0, 0,NOP,8'h00));

    foreach (tbl[i]) apply(tbl[i]);

    // grant withheld three cycles: request and address held steady
    for (int i = 0; i < 3; i++)
      apply(mk(0,0,0,0,0, 8'h4C, 32'h0, 1,8'h4C,0, 0,NOP,8'h00));
    apply(mk(0,0,1,0,0, 8'h4C, 32'h0,        1,8'h4C,1, 0,NOP,8'h00));
    apply(mk(0,0,0,1,0, 8'h50, 32'h00A00007, 0,8'h00,0, 0,NOP,8'h00));

    // reset mid-WAIT with one buffered entry, then a stray rvalid
    apply(mk(0,0,1,0,0, 8'h50, 32'h0,        1,8'h50,1, 1,32'h00A00007,8'h4C));
    apply(mk(1,0,0,0,0, 8'h50, 32'h0,        0,8'h00,0, 1,32'h00A00007,8'h4C));
    apply(mk(1,0,0,1,0, 8'h50, 32'h00A00008, 0,8'h00,0, 0,NOP,8'h00));
    apply(mk(0,0,0,1,0, 8'h50, 32'h00A00009, 1,8'h50,0, 0,NOP,8'h00));
    apply(mk(0,0,0,0,0, 8'h50, 32'h0,        1,8'h50,0, 0,NOP,8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC stage.
- Takes the current PC, issues one request at a time to instruction memory with variable latency, and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Drives pc_en so the PC advances only when a fetch is accepted; a flush discards buffered and in-flight fetches after a taken branch.

Parameters:
- WIDTH, 8: PC / instruction-memory address width.
- DATA_W, 32: instruction width.
- DEPTH, 2: instruction buffer entries (power of two, at least 2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pc_in  input  WIDTH  current PC from PC stage
- pc_en  output  1  one-cycle pulse: PC stage may load next PC
- flush  input  1  redirect (taken branch); discard all fetched/in-flight work
- imem_req  output  1  fetch request
- imem_addr  output  WIDTH  fetch address
- imem_gnt  input  1  memory accepts request this cycle
- imem_rvalid  input  1  response data valid
- imem_rdata  input  DATA_W  response instruction
- instr_valid  output  1  buffer head valid
- instr  output  DATA_W  head instruction; NOP constant when empty
- instr_pc  output  WIDTH  PC of head instruction; 0 when empty
- id_ready  input  1  decode consumes head when instr_valid && id_ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset the state is ISSUE, the buffer is empty and drop=0. imem_req=0, pc_en=0, imem_addr=0, instr_valid=0, instr=NOP, instr_pc=0.
- ISSUE state:
  - imem_req = !flush && count<DEPTH; imem_addr = pc_in (combinational).
  - On imem_req && imem_gnt: pc_en=1 for that cycle, capture pc_in into req_pc, go to WAIT. Otherwise stay.
- WAIT state:
  - imem_req=0, pc_en=0.
  - On imem_rvalid: if drop=0, push {req_pc, imem_rdata}; if drop=1, discard and clear drop. Then return to ISSUE.
  - A response never arrives in the same cycle as its grant; minimum latency is 1 cycle.
- Only one request is outstanding. A request is issued only when count<DEPTH, so the returning response always has a slot and no overflow is possible.
- Pop: instr_valid && id_ready removes the head in the same cycle. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Flush (highest priority):
  - The buffer is cleared next cycle (count=0, pointers reset), any pop is ignored, and imem_req/pc_en are forced 0 that cycle.
  - If in WAIT with no rvalid that cycle: set drop=1 and stay in WAIT.
  - If in WAIT with rvalid the same cycle: discard that response, leave drop=0, go to ISSUE.
  - If in ISSUE: stay in ISSUE.
- A second flush while drop=1 keeps drop=1 (idempotent).
- Reset mid-WAIT: everything returns to reset values; a late rvalid after reset in ISSUE is ignored.
- Throughput: at most one instruction per 2 cycles (grant cycle + response cycle). This is acceptable for the single-cycle datapath.

Decomposition:
- Package if_pkg:
  - state enum {ISSUE, WAIT}
  - NOP constant 32'h0000_0013
  - buffer entry struct {pc, instr}, parameterised via the module using it
- Sub-module if_fifo: synchronous DEPTH-entry FIFO with push/pop/clear, count, and head outputs, reused for later buffering.

Test Plan:
- Reset then pc_in=8'h10, gnt held 1, rvalid 2 cycles after grant with rdata=32'h00500093, id_ready=1 -> pc_en pulses once; instr_valid=1 with instr=32'h00500093, instr_pc=8'h10; instr popped the same cycle.
- id_ready=0, four fetch attempts -> exactly DEPTH=2 pc_en pulses; imem_req stays 0 once count=2; raising id_ready drains in order (pcs 10, 14).
- Flush in WAIT before rvalid -> buffer empties next cycle; the next rvalid (rdata=32'hDEADBEEF) is dropped; the following fetch at new pc_in=8'h40 is delivered with instr_pc=8'h40.
- Flush in the same cycle as rvalid -> the response is not pushed, drop stays 0, the FSM issues the next request the cycle after.
- gnt withheld 3 cycles -> imem_req stays high with a stable addr; pc_en=0 until the grant cycle; no request is issued while flush=1.
- rst asserted mid-WAIT with 1 buffered entry -> next cycle all outputs at reset values; a stray rvalid is ignored and instr_valid stays 0.
